// File: rtl/shift_add_multiplier8bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encodings
// and iteration count.
package shift_add_multiplier8bit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int MUL_ITER = 8;
   localparam int CNT_W    = 3;

endpackage

// File: rtl/carry_skip_adder8bit.sv
// 8-bit carry-skip adder: two 4-bit ripple blocks, each bypassed when all of
// its propagate bits are set.
module carry_skip_adder8bit (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic [7:0] Sum,
   output logic       Cout
);

   logic [7:0] w_p;
   logic [7:0] w_g;
   logic       w_c4;
   logic       w_rip0;
   logic       w_rip1;

   assign w_p = A ^ B;
   assign w_g = A & B;

   always_comb begin
      Sum    = '0;
      w_rip0 = Cin;
      for (int i = 0; i < 4; i++) begin
         Sum[i] = w_p[i] ^ w_rip0;
         w_rip0 = w_g[i] | (w_p[i] & w_rip0);
      end
      w_c4   = (&w_p[3:0]) ? Cin : w_rip0;
      w_rip1 = w_c4;
      for (int i = 4; i < 8; i++) begin
         Sum[i] = w_p[i] ^ w_rip1;
         w_rip1 = w_g[i] | (w_p[i] & w_rip1);
      end
      Cout = (&w_p[7:4]) ? w_c4 : w_rip1;
   end

endmodule

// File: rtl/shift_add_multiplier8bit.sv
// Sequential 8x8 unsigned multiplier: one shift-add step per clock through
// carry_skip_adder8bit, result presented with a one-cycle done pulse.
module shift_add_multiplier8bit
   import shift_add_multiplier8bit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output state_t               dbg_state
);

   // Handshake: start is a request strobe taken only in IDLE (busy=0); any
   // start while busy=1 is dropped. done is a one-cycle pulse with product
   // valid from that cycle until the next completion.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

   state_t                r_state;
   logic [WIDTH-1:0]      r_m;
   logic [2*WIDTH-1:0]    r_p;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic [2*WIDTH-1:0]    r_product;

   logic [WIDTH-1:0]      w_sum;
   logic                  w_cout;
   logic [2*WIDTH-1:0]    w_p_next;

   carry_skip_adder8bit u_adder (
      .A    (r_p[2*WIDTH-1:WIDTH]),
      .B    (r_m),
      .Cin  (1'b0),
      .Sum  (w_sum),
      .Cout (w_cout)
   );

   // Adder carry lands in P[15], so the add path never loses a bit.
   assign w_p_next = r_p[0] ? {w_cout, w_sum, r_p[WIDTH-1:1]}
                            : {1'b0, r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_m       <= '0;
         r_p       <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_m     <= A;
                  r_p     <= {{WIDTH{1'b0}}, B};
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_p   <= w_p_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_state   <= ST_DONE;
                  r_product <= w_p_next;
                  r_done    <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign product   = r_product;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_add_multiplier8bit.sv
// Directed bench for shift_add_multiplier8bit: vector table plus hand-written
// sequences for ignored starts, mid-operation reset and back-to-back starts.
module tb_shift_add_multiplier8bit;
   import shift_add_multiplier8bit_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   state_t      dbg_state;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[6];

   shift_add_multiplier8bit #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .A         (a),
      .B         (b),
      .busy      (busy),
      .done      (done),
      .product   (product),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Full operation: start pulse, then expect done after exactly 8 more edges.
   task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp);
      int n;
      start = 1'b1;
      a     = va;
      b     = vb;
      tick();
      start = 1'b0;
      a     = 8'($urandom_range(0, 255));
      b     = 8'($urandom_range(0, 255));
      check("busy_after_start", busy, 1);
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check("done_latency", n, 8);
      check("product", product, exp);
      check("busy_at_done", busy, 1);
      tick();
      check("idle_after_done", {busy, done}, 2'b00);
      check("product_hold", product, exp);
   endtask

   initial begin
      int n;
      int pulses;
      int next_exp;

      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;

      vecs[0] = '{8'd13,  8'd11,  16'h008F};
      vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
      vecs[2] = '{8'h00,  8'hAB,  16'h0000};
      vecs[3] = '{8'h80,  8'h02,  16'h0100};
      vecs[4] = '{8'h01,  8'h80,  16'h0080};
      vecs[5] = '{8'd200, 8'd100, 16'h4E20};

      tick();
      tick();
      rst = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_product", product, 0);
      check("reset_state", dbg_state, ST_IDLE);

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
         tick();
      end

      // Starts during RUN and DONE must be dropped.
      start = 1'b1; a = 8'd9; b = 8'd7;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      start = 1'b1; a = 8'd3; b = 8'd3;
      tick();
      start = 1'b0;
      n = 4;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check("ign_latency", n, 8);
      check("ign_product", product, 16'h003F);
      start = 1'b1; a = 8'd3; b = 8'd3;
      tick();
      start = 1'b0;
      check("ign_state_idle", dbg_state, ST_IDLE);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) pulses++;
         tick();
      end
      check("ign_no_second_done", pulses, 0);
      check("ign_product_hold", product, 16'h003F);

      // Reset in the middle of RUN aborts and clears product.
      start = 1'b1; a = 8'd200; b = 8'd100;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_product", product, 0);
      check("rst_mid_done", done, 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) pulses++;
         tick();
      end
      check("rst_mid_no_done", pulses, 0);
      run_op(8'd7, 8'd6, 16'h002A);
      tick();

      // start held high: one result every 10 cycles.
      start = 1'b1; a = 8'd5; b = 8'd9;
      tick();
      pulses   = 0;
      next_exp = 8;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (done) begin
            pulses++;
            check("held_done_index", i, next_exp);
            check("held_product", product, 16'h002D);
            next_exp += 10;
         end
      end
      check("held_pulse_count", pulses, 3);
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
